// File: rtl/eks_setup_sequencer_if.sv
// Handshake bundle between the EksBlowfishSetup sequencer and the
// constant loader / expand-key datapath. The sequencer is the master.
interface eks_setup_sequencer_if #(
    parameter int SALT_W = 128
);
    logic              init_start;
    logic              init_done;
    logic              ek_start;
    logic              ek_load_salt;
    logic [SALT_W-1:0] ek_salt;
    logic              ek_key_sel;
    logic              ek_done;

    modport master (
        output init_start,
        output ek_start,
        output ek_load_salt,
        output ek_salt,
        output ek_key_sel,
        input  init_done,
        input  ek_done
    );

    modport slave (
        input  init_start,
        input  ek_start,
        input  ek_load_salt,
        input  ek_salt,
        input  ek_key_sel,
        output init_done,
        output ek_done
    );
endinterface

// File: rtl/eks_setup_sequencer.sv
// EksBlowfishSetup sequencer: constant init, one salted expand-key pass,
// then 2^cost pairs of zero-salt passes (password-keyed, then salt-keyed).
// All outputs are registered; they are computed from the next state so a
// state's outputs are visible during the cycle the FSM sits in that state.
module eks_setup_sequencer #(
    parameter int MIN_COST = 4,
    parameter int MAX_COST = 31,
    parameter int SALT_W   = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4:0]             cost,
    input  logic [SALT_W-1:0]      salt,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   aborted,
    output logic [31:0]            iter_count,
    eks_setup_sequencer_if.master  ek
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT_ISSUE = 4'd1,
        INIT_WAIT  = 4'd2,
        SALT_ISSUE = 4'd3,
        SALT_WAIT  = 4'd4,
        KEY_ISSUE  = 4'd5,
        KEY_WAIT   = 4'd6,
        SKEY_ISSUE = 4'd7,
        SKEY_WAIT  = 4'd8,
        DRAIN      = 4'd9,
        FINISH     = 4'd10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [4:0]          cost_latch_r;
    logic [SALT_W-1:0]   salt_latch_r;
    logic [31:0]         iter_count_r;
    logic                abort_pend_r;
    logic                drain_init_r;

    logic [31:0]         cost_ext_s;
    logic                cost_ok_s;
    logic                accept_s;
    logic                reject_s;
    logic [31:0]         iter_inc_s;
    logic                last_pair_s;
    logic                abort_take_s;
    logic                in_init_s;
    logic                drain_done_s;

    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                error_nxt_s;
    logic                aborted_nxt_s;
    logic                init_start_nxt_s;
    logic                ek_start_nxt_s;
    logic                ek_load_salt_nxt_s;
    logic [SALT_W-1:0]   ek_salt_nxt_s;
    logic                ek_key_sel_nxt_s;

    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic                aborted_r;
    logic                init_start_r;
    logic                ek_start_r;
    logic                ek_load_salt_r;
    logic [SALT_W-1:0]   ek_salt_r;
    logic                ek_key_sel_r;

    // Cost legality, start acceptance, loop termination and abort qualification.
    always_comb begin
        cost_ext_s   = {27'd0, cost};
        cost_ok_s    = (cost_ext_s >= 32'(MIN_COST)) && (cost_ext_s <= 32'(MAX_COST));
        accept_s     = (state_r == IDLE) && start && cost_ok_s;
        reject_s     = (state_r == IDLE) && start && !cost_ok_s;
        iter_inc_s   = iter_count_r + 32'd1;
        // 33-bit compare so cost 31 terminates at 2^31 without overflow.
        last_pair_s  = ({1'b0, iter_inc_s} == (33'd1 << cost_latch_r));
        // Abort only matters while an op is being issued or awaited.
        abort_take_s = abort && (state_r != IDLE) && (state_r != DRAIN) && (state_r != FINISH);
        in_init_s    = (state_r == INIT_ISSUE) || (state_r == INIT_WAIT);
        drain_done_s = drain_init_r ? ek.init_done : ek.ek_done;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. A done pulse coinciding with abort goes straight to FINISH.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = INIT_ISSUE;
                else          state_nxt_s = IDLE;
            end
            INIT_ISSUE: begin
                if (abort) state_nxt_s = DRAIN;
                else       state_nxt_s = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (ek.init_done) state_nxt_s = abort ? FINISH : SALT_ISSUE;
                else if (abort)   state_nxt_s = DRAIN;
                else              state_nxt_s = INIT_WAIT;
            end
            SALT_ISSUE: begin
                if (abort) state_nxt_s = DRAIN;
                else       state_nxt_s = SALT_WAIT;
            end
            SALT_WAIT: begin
                if (ek.ek_done) state_nxt_s = abort ? FINISH : KEY_ISSUE;
                else if (abort) state_nxt_s = DRAIN;
                else            state_nxt_s = SALT_WAIT;
            end
            KEY_ISSUE: begin
                if (abort) state_nxt_s = DRAIN;
                else       state_nxt_s = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (ek.ek_done) state_nxt_s = abort ? FINISH : SKEY_ISSUE;
                else if (abort) state_nxt_s = DRAIN;
                else            state_nxt_s = KEY_WAIT;
            end
            SKEY_ISSUE: begin
                if (abort) state_nxt_s = DRAIN;
                else       state_nxt_s = SKEY_WAIT;
            end
            SKEY_WAIT: begin
                if (ek.ek_done) begin
                    if (abort || last_pair_s) state_nxt_s = FINISH;
                    else                      state_nxt_s = KEY_ISSUE;
                end else if (abort) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = SKEY_WAIT;
                end
            end
            DRAIN: begin
                if (drain_done_s) state_nxt_s = FINISH;
                else              state_nxt_s = DRAIN;
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state; error is decided in IDLE directly.
    always_comb begin
        busy_nxt_s         = (state_nxt_s != IDLE) && (state_nxt_s != FINISH);
        error_nxt_s        = reject_s;
        done_nxt_s         = 1'b0;
        aborted_nxt_s      = 1'b0;
        init_start_nxt_s   = 1'b0;
        ek_start_nxt_s     = 1'b0;
        ek_load_salt_nxt_s = 1'b0;
        ek_salt_nxt_s      = '0;
        ek_key_sel_nxt_s   = 1'b0;
        case (state_nxt_s)
            INIT_ISSUE: begin
                init_start_nxt_s = 1'b1;
            end
            SALT_ISSUE: begin
                ek_start_nxt_s     = 1'b1;
                ek_load_salt_nxt_s = 1'b1;
                ek_salt_nxt_s      = salt_latch_r;
            end
            SALT_WAIT: begin
                ek_salt_nxt_s = salt_latch_r;
            end
            KEY_ISSUE: begin
                ek_start_nxt_s     = 1'b1;
                ek_load_salt_nxt_s = 1'b1;
            end
            SKEY_ISSUE: begin
                ek_start_nxt_s     = 1'b1;
                ek_load_salt_nxt_s = 1'b1;
                ek_key_sel_nxt_s   = 1'b1;
            end
            SKEY_WAIT: begin
                ek_key_sel_nxt_s = 1'b1;
            end
            FINISH: begin
                if (abort_pend_r || abort_take_s) begin
                    aborted_nxt_s = 1'b1;
                end else begin
                    done_nxt_s = 1'b1;
                end
            end
            default: begin
                busy_nxt_s = busy_nxt_s;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            aborted_r      <= 1'b0;
            init_start_r   <= 1'b0;
            ek_start_r     <= 1'b0;
            ek_load_salt_r <= 1'b0;
            ek_salt_r      <= '0;
            ek_key_sel_r   <= 1'b0;
        end else begin
            busy_r         <= busy_nxt_s;
            done_r         <= done_nxt_s;
            error_r        <= error_nxt_s;
            aborted_r      <= aborted_nxt_s;
            init_start_r   <= init_start_nxt_s;
            ek_start_r     <= ek_start_nxt_s;
            ek_load_salt_r <= ek_load_salt_nxt_s;
            ek_salt_r      <= ek_salt_nxt_s;
            ek_key_sel_r   <= ek_key_sel_nxt_s;
        end
    end

    // Run context: latched cost/salt, pair counter, pending-abort bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cost_latch_r <= 5'd0;
            salt_latch_r <= '0;
            iter_count_r <= 32'd0;
            abort_pend_r <= 1'b0;
            drain_init_r <= 1'b0;
        end else begin
            if (accept_s) begin
                cost_latch_r <= cost;
                salt_latch_r <= salt;
                iter_count_r <= 32'd0;
            end else if ((state_r == SKEY_WAIT) && ek.ek_done) begin
                iter_count_r <= iter_inc_s;
            end
            if (state_r == IDLE) begin
                abort_pend_r <= 1'b0;
                drain_init_r <= 1'b0;
            end else if (abort_take_s) begin
                abort_pend_r <= 1'b1;
                drain_init_r <= in_init_s;
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign aborted         = aborted_r;
    assign iter_count      = iter_count_r;
    assign ek.init_start   = init_start_r;
    assign ek.ek_start     = ek_start_r;
    assign ek.ek_load_salt = ek_load_salt_r;
    assign ek.ek_salt      = ek_salt_r;
    assign ek.ek_key_sel   = ek_key_sel_r;

endmodule

// File: tb/tb_eks_setup_sequencer.sv
// Directed bench for eks_setup_sequencer: table of whole runs plus
// hand-written abort, spurious-done and mid-run reset sequences.
module tb_eks_setup_sequencer;

    localparam int RESP_DLY = 5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   cost_in;
    logic [127:0] salt_in;
    logic         abort;
    logic         busy, done, error, aborted;
    logic [31:0]  iter_count;

    logic         start2;
    logic [4:0]   cost2;
    logic         busy2, done2, error2, aborted2;
    logic [31:0]  iter_count2;

    logic         auto_resp;
    logic         auto_init_done;
    logic         auto_ek_done;
    logic         man_ek_done;

    eks_setup_sequencer_if #(.SALT_W(128)) ek_if ();
    eks_setup_sequencer_if #(.SALT_W(128)) ek_if2 ();

    assign ek_if.init_done  = auto_init_done;
    assign ek_if.ek_done    = auto_ek_done | man_ek_done;
    assign ek_if2.init_done = 1'b0;
    assign ek_if2.ek_done   = 1'b0;

    eks_setup_sequencer #(.MIN_COST(4), .MAX_COST(31), .SALT_W(128)) dut (
        .clk(clk), .reset(reset), .start(start), .cost(cost_in), .salt(salt_in),
        .abort(abort), .busy(busy), .done(done), .error(error), .aborted(aborted),
        .iter_count(iter_count), .ek(ek_if.master)
    );

    eks_setup_sequencer #(.MIN_COST(4), .MAX_COST(30), .SALT_W(128)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .cost(cost2), .salt(salt_in),
        .abort(1'b0), .busy(busy2), .done(done2), .error(error2), .aborted(aborted2),
        .iter_count(iter_count2), .ek(ek_if2.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor counters (updated at negedge by the responder process).
    int n_init = 0, n_ek = 0, n_done = 0, n_abt = 0;
    int seq_err = 0, done_busy_err = 0, ek_idx = 0;
    int init_cnt = 0, ek_cnt = 0;
    logic [127:0] cur_salt;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pulse start for one cycle; returns at the negedge where error/busy reflect it.
    task automatic pulse_start(input logic [4:0] c, input logic [127:0] s);
        cur_salt = s;
        salt_in  = s;
        cost_in  = c;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, {127'd0, busy}, 128'd0);
    endtask

    // Monitor of op pulses and auto-responder answering each op RESP_DLY cycles later.
    initial begin
        auto_init_done = 1'b0;
        auto_ek_done   = 1'b0;
        forever begin
            @(negedge clk);
            auto_init_done = 1'b0;
            auto_ek_done   = 1'b0;
            if (ek_if.init_start) n_init++;
            if (ek_if.ek_start) begin
                if (ek_idx == 0) begin
                    if (ek_if.ek_salt !== cur_salt || ek_if.ek_key_sel !== 1'b0 || ek_if.ek_load_salt !== 1'b1)
                        seq_err++;
                end else begin
                    if (ek_if.ek_salt !== 128'd0 || ek_if.ek_load_salt !== 1'b1 ||
                        ek_if.ek_key_sel !== ((ek_idx % 2) == 0))
                        seq_err++;
                end
                ek_idx++;
                n_ek++;
            end
            if (!busy) ek_idx = 0;
            if (done) begin
                n_done++;
                if (busy) done_busy_err++;
            end
            if (aborted) n_abt++;
            if (!auto_resp) begin
                init_cnt = 0;
                ek_cnt   = 0;
            end else begin
                if (init_cnt > 0) begin
                    init_cnt--;
                    if (init_cnt == 0) auto_init_done = 1'b1;
                end
                if (ek_cnt > 0) begin
                    ek_cnt--;
                    if (ek_cnt == 0) auto_ek_done = 1'b1;
                end
                if (ek_if.init_start) init_cnt = RESP_DLY;
                if (ek_if.ek_start)   ek_cnt   = RESP_DLY;
            end
        end
    end

    typedef struct {
        logic [4:0]   cost;
        logic [127:0] salt;
        logic         exp_err;
        int           exp_init;
        int           exp_ek;
        logic [31:0]  exp_iter;
        int           exp_done;
        logic         restart_mid;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int b_init, b_ek, b_done, b_abt, b_seq, b_db;
        int n;
        logic seen;

        vecs[0] = '{5'd4, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1, 33, 32'd16, 1, 1'b0};
        vecs[1] = '{5'd3, 128'h1111,                               1'b1, 0, 0,  32'd16, 0, 1'b0};
        vecs[2] = '{5'd5, 128'hDEADBEEF_CAFEF00D_01020304_A5A5A5A5, 1'b0, 1, 65, 32'd32, 1, 1'b1};
        vecs[3] = '{5'd0, 128'h2222,                               1'b1, 0, 0,  32'd32, 0, 1'b0};

        reset = 1'b0; start = 1'b0; cost_in = 5'd0; salt_in = 128'd0; abort = 1'b0;
        start2 = 1'b0; cost2 = 5'd0; auto_resp = 1'b1; man_ek_done = 1'b0; cur_salt = 128'd0;

        // Reset state
        repeat (3) tick();
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_error", {127'd0, error}, 128'd0);
        check("rst_iter", {96'd0, iter_count}, 128'd0);
        check("rst_ek_start", {127'd0, ek_if.ek_start}, 128'd0);
        check("rst_ek_salt", ek_if.ek_salt, 128'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Table of whole runs
        for (int i = 0; i < 4; i++) begin
            b_init = n_init; b_ek = n_ek; b_done = n_done; b_seq = seq_err; b_db = done_busy_err;
            pulse_start(vecs[i].cost, vecs[i].salt);
            check($sformatf("v%0d_error", i), {127'd0, error}, {127'd0, vecs[i].exp_err});
            check($sformatf("v%0d_busy", i), {127'd0, busy}, {127'd0, !vecs[i].exp_err});
            tick();
            check($sformatf("v%0d_error_1cyc", i), {127'd0, error}, 128'd0);
            if (vecs[i].restart_mid) begin
                repeat (20) tick();
                pulse_start(5'd4, 128'h9999);
                cur_salt = vecs[i].salt;
            end
            wait_idle($sformatf("v%0d_timeout", i), 3000);
            repeat (10) tick();
            check($sformatf("v%0d_init_cnt", i), n_init - b_init, vecs[i].exp_init);
            check($sformatf("v%0d_ek_cnt", i), n_ek - b_ek, vecs[i].exp_ek);
            check($sformatf("v%0d_done_cnt", i), n_done - b_done, vecs[i].exp_done);
            check($sformatf("v%0d_iter", i), {96'd0, iter_count}, {96'd0, vecs[i].exp_iter});
            check($sformatf("v%0d_seq", i), seq_err - b_seq, 0);
            check($sformatf("v%0d_done_busy", i), done_busy_err - b_db, 0);
        end

        // cost=31 rejected when MAX_COST=30
        start2 = 1'b1; cost2 = 5'd31;
        tick();
        start2 = 1'b0;
        check("max30_error", {127'd0, error2}, 128'd1);
        check("max30_busy", {127'd0, busy2}, 128'd0);
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (ek_if2.init_start || ek_if2.ek_start || busy2) seen = 1'b1;
        end
        check("max30_no_ops", {127'd0, seen}, 128'd0);

        // cost=31 legal on default instance; abort during INIT_ISSUE drains init
        b_abt = n_abt; b_done = n_done; b_ek = n_ek;
        pulse_start(5'd31, 128'h3333);
        check("c31_error", {127'd0, error}, 128'd0);
        check("c31_busy", {127'd0, busy}, 128'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("c31_timeout", 100);
        repeat (5) tick();
        check("c31_aborted", n_abt - b_abt, 1);
        check("c31_no_done", n_done - b_done, 0);
        check("c31_no_ek", n_ek - b_ek, 0);

        // Abort in KEY_WAIT at iter_count=3, ek_done 4 cycles after abort
        pulse_start(5'd4, 128'h4444);
        n = 0;
        while (!(ek_if.ek_start && !ek_if.ek_key_sel && iter_count == 32'd3) && n < 2000) begin
            tick();
            n++;
        end
        check("abt_reach", {127'd0, (n < 2000)}, 128'd1);
        auto_resp = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        b_ek = n_ek; b_done = n_done;
        repeat (3) tick();
        check("abt_busy_drain", {127'd0, busy}, 128'd1);
        man_ek_done = 1'b1;
        tick();
        man_ek_done = 1'b0;
        check("abt_aborted", {127'd0, aborted}, 128'd1);
        check("abt_done", {127'd0, done}, 128'd0);
        check("abt_busy", {127'd0, busy}, 128'd0);
        tick();
        check("abt_aborted_1cyc", {127'd0, aborted}, 128'd0);
        repeat (5) tick();
        check("abt_no_ek", n_ek - b_ek, 0);
        check("abt_no_done", n_done - b_done, 0);
        check("abt_iter", {96'd0, iter_count}, 128'd3);
        auto_resp = 1'b1;

        // Spurious ek_done in IDLE
        man_ek_done = 1'b1;
        tick();
        man_ek_done = 1'b0;
        tick();
        check("spur_idle_busy", {127'd0, busy}, 128'd0);
        check("spur_idle_iter", {96'd0, iter_count}, 128'd3);

        // Spurious ek_done in KEY_ISSUE; run still completes normally
        b_ek = n_ek; b_done = n_done;
        pulse_start(5'd4, 128'h5555);
        n = 0;
        while (!(ek_if.ek_start && !ek_if.ek_key_sel && iter_count == 32'd1) && n < 2000) begin
            tick();
            n++;
        end
        man_ek_done = 1'b1;
        tick();
        man_ek_done = 1'b0;
        check("spur_key_iter", {96'd0, iter_count}, 128'd1);
        wait_idle("spur_key_timeout", 3000);
        repeat (10) tick();
        check("spur_key_ek_cnt", n_ek - b_ek, 33);
        check("spur_key_done", n_done - b_done, 1);
        check("spur_key_final_iter", {96'd0, iter_count}, 128'd16);

        // Reset during SKEY_WAIT; stale ek_done ignored; fresh run completes
        pulse_start(5'd4, 128'h6666);
        n = 0;
        while (!(ek_if.ek_start && ek_if.ek_key_sel && iter_count == 32'd2) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_mid_busy", {127'd0, busy}, 128'd0);
        check("rst_mid_iter", {96'd0, iter_count}, 128'd0);
        check("rst_mid_key_sel", {127'd0, ek_if.ek_key_sel}, 128'd0);
        repeat (8) tick();
        check("rst_mid_stale_busy", {127'd0, busy}, 128'd0);
        check("rst_mid_stale_iter", {96'd0, iter_count}, 128'd0);
        b_ek = n_ek; b_done = n_done; b_seq = seq_err;
        pulse_start(5'd4, 128'h7777);
        wait_idle("rst_fresh_timeout", 3000);
        repeat (10) tick();
        check("rst_fresh_ek_cnt", n_ek - b_ek, 33);
        check("rst_fresh_done", n_done - b_done, 1);
        check("rst_fresh_iter", {96'd0, iter_count}, 128'd16);
        check("rst_fresh_seq", seq_err - b_seq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eks_setup_sequencer.md
Name: eks_setup_sequencer

Overview:
- Sequences the bcrypt EksBlowfishSetup schedule around the expand-key datapath (P-array/S-box SRAM pair plus Feistel core).
- Order of work: S-box/P-array constant init, one salted expand-key pass, then 2^cost pairs of zero-salt expand-key passes. The first pass of each pair is keyed by the password, the second by the salt.
- Sits between the top-level bcrypt controller and the expand-key block. It owns the start/done handshake, the salt/key selection and the iteration count.

Parameters:
- MIN_COST, 4, smallest legal cost factor.
- MAX_COST, 31, largest legal cost factor.
- SALT_W, 128, salt width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- start  in  1  request a setup run; sampled only in IDLE
- cost  in  5  cost factor; latched with start
- salt  in  SALT_W  salt; latched with start
- abort  in  1  stop the current run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse on normal completion
- error  out  1  one-cycle pulse when cost is rejected
- aborted  out  1  one-cycle pulse when an abort completes
- iter_count  out  32  completed loop pairs in the current run
- init_start  out  1  one-cycle pulse to the constant loader
- init_done  in  1  one-cycle pulse from the constant loader
- ek_start  out  1  one-cycle pulse that launches expand-key
- ek_load_salt  out  1  high with ek_start; expand-key latches ek_salt
- ek_salt  out  SALT_W  salt_latch in the SALT phase, 0 in loop phases
- ek_key_sel  out  1  0 = password feeds key bytes, 1 = salt feeds key bytes
- ek_done  in  1  one-cycle pulse from expand-key when a pass completes

Behaviour:
- Reset: reset=0 at a clk edge forces state IDLE. All outputs go to 0, including ek_salt. salt_latch, cost_latch and iter_count are cleared. This applies mid-run; any in-flight datapath op is abandoned.
- States: IDLE, INIT_ISSUE, INIT_WAIT, SALT_ISSUE, SALT_WAIT, KEY_ISSUE, KEY_WAIT, SKEY_ISSUE, SKEY_WAIT, DRAIN, FINISH.
- IDLE:
  - start=1 with cost<MIN_COST or cost>MAX_COST: pulse error next cycle, stay in IDLE, issue no ops.
  - start=1 with legal cost: latch cost and salt, clear iter_count, go to INIT_ISSUE. busy rises the cycle after start.
- INIT_ISSUE: pulse init_start for 1 cycle, then INIT_WAIT.
- INIT_WAIT: on init_done go to SALT_ISSUE.
- SALT_ISSUE: pulse ek_start with ek_load_salt=1, ek_salt=salt_latch, ek_key_sel=0. Then SALT_WAIT.
- SALT_WAIT: on ek_done go to KEY_ISSUE.
- KEY_ISSUE: pulse ek_start with ek_load_salt=1, ek_salt=0, ek_key_sel=0. Then KEY_WAIT.
- KEY_WAIT: on ek_done go to SKEY_ISSUE.
- SKEY_ISSUE: pulse ek_start with ek_load_salt=1, ek_salt=0, ek_key_sel=1. Then SKEY_WAIT.
- SKEY_WAIT: on ek_done, iter_count increments.
  - If the new count equals 1<<cost_latch (33-bit compare; cost 31 gives 2^31), go to FINISH.
  - Otherwise go to KEY_ISSUE.
- FINISH: pulse done, drop busy, return to IDLE. iter_count holds its value until the next accepted start.
- ek_salt and ek_key_sel hold their issue-cycle values through the matching WAIT state. Elsewhere they are 0.
- Handshake rules:
  - ek_done and init_done are sampled only in the matching WAIT state and ignored elsewhere.
  - start is ignored while busy.
  - Each ISSUE state lasts exactly 1 cycle, so back-to-back ops carry a 1-cycle gap.
- Abort:
  - In an ISSUE state the pulse still goes out, then the FSM enters DRAIN.
  - In a WAIT state the FSM enters DRAIN, unless the done pulse arrives in the same cycle; then it goes straight to FINISH-abort.
  - DRAIN waits for the outstanding ek_done or init_done.
  - FINISH-abort pulses aborted instead of done, drops busy and returns to IDLE.
  - abort in IDLE has no effect.
  - Abort and the final ek_done in the same cycle: abort wins; aborted pulses and done does not.
- Op count per run: 2 + 2·2^cost ops (1 init plus 1 + 2·2^cost expand-key).

Test Plan:
- Reset, then start with cost=4 and salt=128'h0123..EF, answering each op after 5 cycles -> 1 init_start and 33 ek_start. The first carries ek_salt=salt and key_sel=0; the remaining 32 alternate key_sel 0,1 with ek_salt=0. iter_count ends at 16, done pulses once, busy falls the same cycle.
- start with cost=3, and separately cost=31 with MAX_COST=30 -> error pulse the next cycle, busy stays 0, no init_start or ek_start.
- cost=5 run -> 65 ek_start pulses, iter_count=32, done pulses once. A second start during the run is ignored.
- abort in KEY_WAIT when iter_count=3, with ek_done 4 cycles later -> no further ek_start, aborted pulses the cycle after ek_done, done never pulses, iter_count=3.
- Spurious ek_done while in IDLE or KEY_ISSUE -> no state change and no count increment.
- reset=0 during SKEY_WAIT -> the next cycle shows IDLE with busy=0 and iter_count=0. A later ek_done is ignored, and a fresh cost=4 start completes normally.
